// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcodes, FSM state
// encodings and the datapath select codes.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that stall on the memory handshake and are watched by the timer.
  function automatic logic is_wait_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles in a memory wait state and flags a
// timeout once MEM_TIMEOUT stalls have elapsed without mem_ready.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wait_en,
  input  logic mem_ready,
  output logic timeout
);

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  // Any cycle that does not keep stalling leaves the wait state, so the
  // counter is already zero when the next wait state is entered.
  always_comb begin
    timeout = wait_en && !mem_ready && (cnt_q == LIMIT);
    cnt_d   = '0;
    if (wait_en && !mem_ready && !timeout) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: Moore-decoded datapath controls, with the
// FETCH write enables qualified by mem_ready and a memory-timeout HALT.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       illegal,
  output logic       bus_err
);

  state_e state_q, state_d;
  logic   wait_en;
  logic   timeout;

  assign wait_en = is_wait_state(state_q);
  assign state   = state_q;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .wait_en  (wait_en),
    .mem_ready(mem_ready),
    .timeout  (timeout)
  );

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    illegal       = 1'b0;
    bus_err       = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        state_d       = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        state_d   = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // timeout is only raised while stalled, so mem_ready always wins.
    if (timeout) begin
      bus_err = 1'b1;
      state_d = S_HALT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized instruction-level bench for multicycle_ctrl: builds the expected
// per-cycle state/output trace of each instruction and compares every cycle.
module tb_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic       illegal, bus_err;

  multicycle_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .illegal(illegal), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  logic [21:0] obs;
  assign obs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                pc_source, illegal, bus_err, state};

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  function automatic logic legal_op(input logic [5:0] opc);
    return opc inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
  endfunction

  // Expected control word for one cycle spent in state st.
  function automatic logic [21:0] model_out(input state_e st, input logic rdy,
                                            input logic [5:0] opc, input logic berr);
    logic pcw, pcwc, io, mrd, mwr, irw, m2r, rdst, rw, sa, ill;
    logic [1:0] sb, ao, ps;
    {pcw, pcwc, io, mrd, mwr, irw, m2r, rdst, rw, sa, ill} = '0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (st)
      S_FETCH:  begin mrd = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
      S_DECODE: begin sb = 2'b11; ill = !legal_op(opc); end
      S_MEMADR: begin sa = 1; sb = 2'b10; end
      S_MEMRD:  begin mrd = 1; io = 1; end
      S_MEMWB:  begin m2r = 1; rw = 1; end
      S_MEMWR:  begin mwr = 1; io = 1; end
      S_EXEC:   begin sa = 1; ao = 2'b10; end
      S_ALUWB:  begin rdst = 1; rw = 1; end
      S_BRANCH: begin sa = 1; ao = 2'b01; pcwc = 1; ps = 2'b01; end
      S_ADDIEX: begin sa = 1; sb = 2'b10; end
      S_ADDIWB: begin rw = 1; end
      S_JUMP:   begin pcw = 1; ps = 2'b10; end
      default:  ;
    endcase
    return {pcw, pcwc, io, mrd, mwr, irw, m2r, rdst, rw, sa, sb, ao, ps, ill, berr, st};
  endfunction

  typedef struct {
    logic        rdy;
    logic [5:0]  opc;
    logic [21:0] exp;
    string       tag;
  } step_t;

  step_t plan[$];

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input state_e st, input logic rdy, input logic [5:0] opc, input logic berr);
    step_t s;
    s.rdy = rdy;
    s.opc = opc;
    s.exp = model_out(st, rdy, opc, berr);
    s.tag = st.name();
    plan.push_back(s);
  endtask

  // One instruction: fw stalled FETCH cycles, mw stalled memory cycles.
  task automatic plan_instr(input logic [5:0] opc, input int fw, input int mw);
    for (int i = 0; i < fw; i++) push(S_FETCH, 1'b0, opc, 1'b0);
    push(S_FETCH, 1'b1, opc, 1'b0);
    push(S_DECODE, rnd_bit(), opc, 1'b0);
    case (opc)
      OP_LW: begin
        push(S_MEMADR, rnd_bit(), opc, 1'b0);
        for (int i = 0; i < mw; i++) push(S_MEMRD, 1'b0, opc, 1'b0);
        push(S_MEMRD, 1'b1, opc, 1'b0);
        push(S_MEMWB, rnd_bit(), opc, 1'b0);
      end
      OP_SW: begin
        push(S_MEMADR, rnd_bit(), opc, 1'b0);
        for (int i = 0; i < mw; i++) push(S_MEMWR, 1'b0, opc, 1'b0);
        push(S_MEMWR, 1'b1, opc, 1'b0);
      end
      OP_RTYPE: begin push(S_EXEC, rnd_bit(), opc, 1'b0); push(S_ALUWB, rnd_bit(), opc, 1'b0); end
      OP_BEQ:   push(S_BRANCH, rnd_bit(), opc, 1'b0);
      OP_ADDI:  begin push(S_ADDIEX, rnd_bit(), opc, 1'b0); push(S_ADDIWB, rnd_bit(), opc, 1'b0); end
      OP_J:     push(S_JUMP, rnd_bit(), opc, 1'b0);
      default:  ;
    endcase
  endtask

  // Stall in st for TIMEOUT+1 cycles; the last one raises bus_err, then HALT.
  task automatic plan_stall_out(input state_e st, input logic [5:0] opc);
    for (int i = 0; i < TIMEOUT; i++) push(st, 1'b0, opc, 1'b0);
    push(st, 1'b0, opc, 1'b1);
    for (int i = 0; i < 5; i++) push(S_HALT, rnd_bit(), opc, 1'b0);
  endtask

  // Each step: drive inputs just after a falling edge, check, move on a cycle.
  task automatic run_plan();
    step_t s;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      opcode    = s.opc;
      mem_ready = s.rdy;
      #1;
      check_eq(s.tag, 32'(obs), 32'(s.exp));
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    #1;
    check_eq("reset_outputs", 32'(obs), 32'(model_out(S_FETCH, 1'b0, opcode, 1'b0)));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 6))
      0: return OP_RTYPE;
      1: return OP_LW;
      2: return OP_SW;
      3: return OP_BEQ;
      4: return OP_ADDI;
      5: return OP_J;
      default: return 6'($urandom_range(0, 63));
    endcase
  endfunction

  function automatic int pick_wait();
    if ($urandom_range(0, 7) == 0) return TIMEOUT;
    return $urandom_range(0, 3);
  endfunction

  initial begin
    do_reset();

    plan_instr(OP_RTYPE, 0, 0);
    plan_instr(OP_LW, 0, 3);
    plan_instr(OP_BEQ, 0, 0);
    plan_instr(OP_J, 0, 0);
    plan_instr(6'b111111, 0, 0);
    plan_instr(OP_SW, 2, 1);
    plan_instr(OP_ADDI, TIMEOUT, 0);
    plan_instr(OP_LW, 1, TIMEOUT);
    plan_instr(OP_SW, 0, TIMEOUT);
    run_plan();

    for (int n = 0; n < 150; n++) begin
      plan_instr(pick_op(), pick_wait(), pick_wait());
      run_plan();
    end

    // Memory timeouts in each wait state, each recovered by a reset pulse.
    plan_stall_out(S_FETCH, OP_RTYPE);
    run_plan();
    do_reset();
    plan_instr(OP_RTYPE, 0, 0);
    push(S_FETCH, 1'b1, OP_LW, 1'b0);
    push(S_DECODE, 1'b0, OP_LW, 1'b0);
    push(S_MEMADR, 1'b0, OP_LW, 1'b0);
    plan_stall_out(S_MEMRD, OP_LW);
    run_plan();
    do_reset();
    push(S_FETCH, 1'b1, OP_SW, 1'b0);
    push(S_DECODE, 1'b1, OP_SW, 1'b0);
    push(S_MEMADR, 1'b1, OP_SW, 1'b0);
    plan_stall_out(S_MEMWR, OP_SW);
    run_plan();
    do_reset();

    // Asynchronous reset between clock edges while a store is stalled.
    push(S_FETCH, 1'b1, OP_SW, 1'b0);
    push(S_DECODE, 1'b0, OP_SW, 1'b0);
    push(S_MEMADR, 1'b0, OP_SW, 1'b0);
    push(S_MEMWR, 1'b0, OP_SW, 1'b0);
    push(S_MEMWR, 1'b0, OP_SW, 1'b0);
    run_plan();
    mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_outputs", 32'(obs), 32'(model_out(S_FETCH, 1'b0, OP_SW, 1'b0)));
    check_eq("async_rst_mem_write", 32'(mem_write), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    plan_instr(OP_LW, 0, 0);
    plan_instr(OP_ADDI, 0, 0);
    run_plan();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "bench did not complete");
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, meaning max consecutive cycles a memory state waits for mem_ready before fault.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 opcode  input  6  instruction[31:26] from the instruction register.
REQ-005 mem_ready  input  1  memory completes the current read/write this cycle.
REQ-006 pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  output  1 each  datapath enables and selects.
REQ-007 alu_src_b, alu_op, pc_source  output  2 each  datapath selects.
REQ-008 state  output  4  current FSM state, for debug.
REQ-009 illegal  output  1  one-cycle pulse on an unsupported opcode.
REQ-010 bus_err  output  1  one-cycle pulse on memory timeout.

Function
REQ-011 States SHALL be: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, HALT.
REQ-012 Any output not listed for a state SHALL be 0; all outputs are Moore-decoded from state, except the mem_ready-qualified outputs in REQ-013.
REQ-013 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready; next state = DECODE if mem_ready, else FETCH.
REQ-014 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next state by opcode: 100011/101011->MEMADR, 000000->EXEC, 000100->BRANCH, 001000->ADDIEX, 000010->JUMP; any other opcode -> FETCH with illegal=1 for that cycle.
REQ-015 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; next state MEMRD for lw (100011), MEMWR for sw (101011).
REQ-016 MEMRD: mem_read=1, iord=1; next state MEMWB on mem_ready, else hold.
REQ-017 MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1; next state FETCH.
REQ-018 MEMWR: mem_write=1, iord=1; next state FETCH on mem_ready, else hold.
REQ-019 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1 -> FETCH.
REQ-020 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH.
REQ-021 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1 -> FETCH.
REQ-022 JUMP: pc_write=1, pc_source=10 -> FETCH.
REQ-023 Wait counter: clears to 0 on entering FETCH, MEMRD or MEMWR; increments each cycle in those states while mem_ready=0; width = clog2(MEM_TIMEOUT+1).
REQ-024 When counter equals MEM_TIMEOUT with mem_ready=0, bus_err=1 for that cycle and next state = HALT; mem_ready=1 on that same cycle SHALL win (normal advance, no bus_err).
REQ-025 HALT: all enables 0, held until rst_n asserted.
REQ-026 Instruction latencies, zero-wait memory: R-type/addi/branch/jump 3-4 cycles (FETCH, DECODE, 1-2 exec states), sw 4, lw 5.

Reset
REQ-027 rst_n=0 SHALL immediately force state=FETCH, counter=0, illegal=0, bus_err=0, independent of clk.
REQ-028 Reset asserted mid-instruction (including during wait states or HALT) SHALL abandon it; first cycle after release is FETCH with mem_read=1.

Structure
REQ-029 Shared package mips_ctrl_pkg SHALL hold opcode constants, state encodings, alu_op codes (00 add, 01 sub, 10 funct), alu_src_b and pc_source codes.
REQ-030 One sub-module mem_wait_timer SHALL implement REQ-023/REQ-024 counting and the timeout flag; FSM and output decode stay in multicycle_ctrl.

Verification
REQ-031 Reset, mem_ready=1, opcode=000000 -> states FETCH, DECODE, EXEC, ALUWB, FETCH; reg_write=1 and reg_dst=1 only in ALUWB.
REQ-032 opcode=100011, mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB with mem_to_reg=1, reg_write=1; bus_err stays 0.
REQ-033 opcode=000100 -> BRANCH with pc_write_cond=1, pc_source=01, alu_op=01; opcode=000010 -> JUMP with pc_write=1, pc_source=10.
REQ-034 opcode=111111 at DECODE -> illegal=1 for one cycle, next state FETCH, no write enable asserted.
REQ-035 mem_ready=0 held in FETCH, MEM_TIMEOUT=15 -> bus_err=1 on 16th FETCH cycle, then HALT persists; rst_n pulse -> FETCH.
REQ-036 rst_n asserted mid-cycle during MEMWR -> outputs drop to FETCH values before next clk edge, mem_write=0.
